// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and operand/result bus between the control unit and muldiv_unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, opA, opB,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Divide support is compiled only when MULDIV_DIV_EN is defined; otherwise every op multiplies.
module muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_next;
`ifdef MULDIV_DIV_EN
  logic               op_q, op_d;
  logic               dz_q, dz_d;
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_trial;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
`ifdef MULDIV_DIV_EN
      op_q     <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
`ifdef MULDIV_DIV_EN
      op_q     <= op_d;
      dz_q     <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;

    // Shift-add: add multiplicand into the high half, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    step_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    op_d = op_q;
    dz_d = dz_q;
    // Restoring step: acc high = partial remainder, acc low = quotient; dividend bits from a_q MSB.
    div_part  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_trial = div_part - {1'b0, b_q};
    if (op_q) begin
      if (!div_trial[WIDTH]) begin
        step_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_next = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.opA;
          b_d     = bus.opB;
          cnt_d   = CntW'(WIDTH);
          acc_d   = '0;
          state_d = StRun;
`ifdef MULDIV_DIV_EN
          op_d = bus.op;
          dz_d = 1'b0;
          if (bus.op && (bus.opB == '0)) begin
            state_d  = StDone;
            res_lo_d = '1;
            res_hi_d = bus.opA;
            dz_d     = 1'b1;
          end
`endif
        end
      end
      StRun: begin
        acc_d = step_next;
        cnt_d = cnt_q - CntW'(1);
`ifdef MULDIV_DIV_EN
        if (op_q) begin
          a_d = {a_q[WIDTH-2:0], 1'b0};
        end else begin
          b_d = b_q >> 1;
        end
`else
        b_d = b_q >> 1;
`endif
        if (cnt_q == CntW'(1)) begin
          state_d  = StDone;
          res_lo_d = step_next[WIDTH-1:0];
          res_hi_d = step_next[2*WIDTH-1:WIDTH];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
`ifdef MULDIV_DIV_EN
  assign bus.div_by_zero = dz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations adapt to whether MULDIV_DIV_EN is set.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(16)) bus ();

  muldiv_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion; inject=1 pokes start during RUN and DONE.
  task automatic run_op(input string tag, input bit op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_hi, input logic [15:0] exp_lo, input bit exp_dz,
                        input int exp_lat, input bit inject);
    int lat;
    int extra_done;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        bus.start = 1'b0;
        bus.opA   = ~a;
        bus.opB   = ~b;
        check_eq({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
      end
      if (inject && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opA   = 16'hFFFF;
        bus.opB   = 16'hFFFF;
      end
      if (inject && n == 6) bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_hi"}, 32'(bus.result_hi), 32'(exp_hi));
    check_eq({tag, "_lo"}, 32'(bus.result_lo), 32'(exp_lo));
    check_eq({tag, "_dz"}, 32'(bus.div_by_zero), 32'(exp_dz));
    if (inject) begin
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.opA   = 16'h0007;
      bus.opB   = 16'h0009;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    if (inject) begin
      extra_done = 0;
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (bus.done) extra_done++;
      end
      check_eq({tag, "_extra_done"}, 32'(extra_done), 32'd0);
      check_eq({tag, "_hold_lo"}, 32'(bus.result_lo), 32'(exp_lo));
    end
  endtask

  initial begin
    int seen_done;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_lo", 32'(bus.result_lo), 32'd0);
    check_eq("rst_hi", 32'(bus.result_hi), 32'd0);
    check_eq("rst_dz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    run_op("mul_basic", 1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 16, 1'b0);
    run_op("mul_max", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16, 1'b0);
    // 100/7 = 14 r 2; as a multiply 100*7 = 700
    run_op("div_basic", 1'b1, 16'd100, 16'd7, DivEn ? 16'd2 : 16'd0,
           DivEn ? 16'd14 : 16'd700, 1'b0, 16, 1'b0);
    // 0xFFFF/0x10 = 0x0FFF r 0xF; as a multiply 0xFFFF0
    run_op("div_big", 1'b1, 16'hFFFF, 16'h0010, DivEn ? 16'h000F : 16'h000F,
           DivEn ? 16'h0FFF : 16'hFFF0, 1'b0, 16, 1'b0);
    run_op("div_zero", 1'b1, 16'h0005, 16'h0000, DivEn ? 16'h0005 : 16'h0000,
           DivEn ? 16'hFFFF : 16'h0000, DivEn, DivEn ? 0 : 16, 1'b0);
    // Next accepted start clears the divide-by-zero flag.
    run_op("dz_clear", 1'b0, 16'h0002, 16'h0004, 16'h0000, 16'h0008, 1'b0, 16, 1'b0);

    // Reset during RUN cycle 8 aborts the operation with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opA   = 16'h1234;
    bus.opB   = 16'h0010;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_lo", 32'(bus.result_lo), 32'd0);
    check_eq("abort_hi", 32'(bus.result_hi), 32'd0);
    seen_done = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check_eq("abort_no_done", 32'(seen_done), 32'd0);

    // 0x0102 * 0x0304 = 0x00030A08; start pokes during RUN and DONE must be ignored.
    run_op("busy_ignore", 1'b0, 16'h0102, 16'h0304, 16'h0003, 16'h0A08, 1'b0, 16, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
